// File: rtl/mips_pkg.sv
// Shared sizing and types for the MIPS register file and its scoreboard.
package mips_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at
// writeback, and the decode stall derived from it.
module rf_scoreboard #(
  parameter int NUM_REGS = mips_pkg::NUM_REGS,
  parameter int ADDR_W   = mips_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              stall,
  output logic              pending_any
);
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [NUM_REGS-1:0] set_vec, clr_vec;
  logic                pending_any_q, pending_any_d;
  logic                hz_a, hz_b;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid) set_vec[issue_dest] = 1'b1;
    if (wr_en)       clr_vec[wr_addr]    = 1'b1;
    // Set beats clear: a newer producer is in flight for that register.
    pend_d        = (pend_q & ~clr_vec) | set_vec;
    pend_d[0]     = 1'b0;
    pending_any_d = |pend_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q        <= '0;
      pending_any_q <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      pending_any_q <= pending_any_d;
    end
  end

  // A same-cycle writeback to the source is forwarded by the read bypass.
  always_comb begin
    hz_a = rd_en_a && (rd_addr_a != '0) && pend_q[rd_addr_a]
           && !(wr_en && (wr_addr == rd_addr_a));
    hz_b = rd_en_b && (rd_addr_b != '0) && pend_q[rd_addr_b]
           && !(wr_en && (wr_addr == rd_addr_b));
  end

  assign stall       = hz_a | hz_b;
  assign pending_any = pending_any_q;
endmodule

// File: rtl/mips_regfile.sv
// 32x32 MIPS register file: one write port, two registered read ports with
// write-through bypass, and a pending-write scoreboard driving decode stall.
module mips_regfile #(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int NUM_REGS = mips_pkg::NUM_REGS,
  parameter int ADDR_W   = mips_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rf_write_en,
  input  logic [ADDR_W-1:0] rf_write_addr,
  input  logic [DATA_W-1:0] rf_write_data,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              stall,
  output logic              pending_any
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DATA_W-1:0]               rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0]               rd_data_b_q, rd_data_b_d;
  logic                            wr_live;

  assign wr_live = rf_write_en && (rf_write_addr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_live) regs_d[rf_write_addr] = rf_write_data;
  end

  // Reads are refreshed every cycle; the enables only qualify the stall.
  always_comb begin
    if (rd_addr_a == '0)                   rd_data_a_d = '0;
    else if (wr_live && rf_write_addr == rd_addr_a) rd_data_a_d = rf_write_data;
    else                                   rd_data_a_d = regs_q[rd_addr_a];
    if (rd_addr_b == '0)                   rd_data_b_d = '0;
    else if (wr_live && rf_write_addr == rd_addr_b) rd_data_b_d = rf_write_data;
    else                                   rd_data_b_d = regs_q[rd_addr_b];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q      <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
    end else begin
      regs_q      <= regs_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (rf_write_en),
    .wr_addr     (rf_write_addr),
    .rd_en_a     (rd_en_a),
    .rd_addr_a   (rd_addr_a),
    .rd_en_b     (rd_en_b),
    .rd_addr_b   (rd_addr_b),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .stall       (stall),
    .pending_any (pending_any)
  );
endmodule

// File: doc/mips_regfile.md
Name: mips_regfile

Overview:
- 32 x 32-bit MIPS general-purpose register file.
- Receives the writeback stage's single write port (address, data, enable) and serves two registered read ports to the decode stage.
- Includes a per-register pending-write scoreboard. The scoreboard raises a stall to decode when a source operand has an in-flight producer that has not yet been written back.
- Sits between writeback (writer) and decode/issue (reader).

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers.
- ADDR_W, 5, register address width; must equal $clog2(NUM_REGS).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rf_write_en  in  1  writeback write strobe.
- rf_write_addr  in  ADDR_W  writeback destination register.
- rf_write_data  in  DATA_W  writeback data (ALU result or load data).
- rd_en_a  in  1  operand A is used by the instruction in decode.
- rd_addr_a  in  ADDR_W  operand A register (rs).
- rd_en_b  in  1  operand B is used by the instruction in decode.
- rd_addr_b  in  ADDR_W  operand B register (rt).
- rd_data_a  out  DATA_W  registered operand A data.
- rd_data_b  out  DATA_W  registered operand B data.
- issue_valid  in  1  an instruction leaving decode will write a register.
- issue_dest  in  ADDR_W  destination of the issuing instruction.
- stall  out  1  combinational: decode must hold this cycle.
- pending_any  out  1  registered: at least one scoreboard bit is set.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately, including mid-operation):
  - all registers cleared to 0;
  - rd_data_a and rd_data_b = 0;
  - all pending bits = 0;
  - pending_any = 0;
  - stall evaluates to 0.
- Register 0:
  - always reads 0;
  - writes to it are discarded;
  - never marked pending.
- Write:
  - at posedge clk, if rf_write_en and rf_write_addr != 0, then reg[rf_write_addr] <= rf_write_data.
- Read (one-cycle latency):
  - at posedge clk, rd_data_x <= 0 if rd_addr_x == 0;
  - else rf_write_data if rf_write_en and rf_write_addr == rd_addr_x (same-cycle write-through bypass);
  - else reg[rd_addr_x].
  - Reads update every cycle regardless of rd_en_x. rd_en_x only qualifies stall.
- Scoreboard, per register r != 0, evaluated at posedge:
  - set term: issue_valid and issue_dest == r;
  - clear term: rf_write_en and rf_write_addr == r;
  - if set and clear coincide on the same r, set wins, because a newer producer is now in flight;
  - otherwise the bit holds.
  - issue_valid is recorded even while stall is high; decode must not issue during stall.
- Stall: stall = hz_a | hz_b, where
  - hz_x = rd_en_x and rd_addr_x != 0 and pending[rd_addr_x] and not (rf_write_en and rf_write_addr == rd_addr_x).
  - The writeback in the same cycle resolves the hazard through the bypass, so no stall is raised.
- pending_any is the registered OR of the next-state pending vector.
- Clearing a bit that is not pending (a write with no prior issue) is legal and has no effect beyond the data write.
- The block introduces no X propagation: out-of-range addresses cannot occur because ADDR_W matches NUM_REGS.

Decomposition:
- Shared package mips_pkg holds:
  - REG_ADDR_W, NUM_REGS, DATA_W, REG_ZERO = 5'd0;
  - typedef reg_addr_t = logic [REG_ADDR_W-1:0];
  - typedef word_t = logic [DATA_W-1:0].
- One sub-module, rf_scoreboard, is natural:
  - contains the pending vector, the set/clear priority, pending_any, and the hz_a/hz_b/stall logic;
  - the storage array and read bypass stay in mips_regfile.

Test Plan:
- Reset, then write r5 = 0xDEADBEEF, then read r5 on port A the next cycle: rd_data_a = 0xDEADBEEF one cycle after the address is applied.
- Write r0 = 0x12345678, then read r0 on both ports: rd_data_a = rd_data_b = 0; issue_valid with issue_dest = 0 leaves pending_any = 0.
- Same-cycle write r7 = 0xA5A5A5A5 while reading r7 on A and B: both ports show 0xA5A5A5A5 after one cycle (bypass), not the old value.
- Scoreboard sequence:
  - issue_dest = 9, next cycle read r9 with rd_en_a = 1: stall = 1 and pending_any = 1;
  - rf_write_en at r9 in that same cycle: stall = 0 that cycle, and the pending bit clears next cycle;
  - with rd_en_a = 0 and rd_en_b = 0 while r9 is pending: stall = 0.
- Simultaneous issue_dest = 3 and rf_write_en at r3: the bit stays set; a later read of r3 with rd_en_b = 1 stalls until another write to r3 arrives.
- Assert rst_n low asynchronously mid-cycle with r4 pending and r4 = 0x55: outputs go to 0 immediately and stall = 0; after release, reading r4 returns 0.
